// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame width and default bit timing.
// Also imported by the matching transmitter, so the default baud divisor lives here.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; q follows d after two clk edges.
// No handshake; the reset value is chosen per input so a reset never fakes an edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx_dv/rx_byte 3 + HALF_BIT + 9*CLKS_PER_BIT clocks after the start edge.
// No backpressure: rx_dv is a single-cycle strobe and a byte not taken on it is lost.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    // Preset high so a reset never looks like a start edge on an idle line.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_byte      <= 8'h00;
            rx_dv        <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_dv        <= 1'b0;
            rx_frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // A line back high at the start-bit centre was only a glitch.
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx_byte <= shift;
                            rx_dv   <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= ST_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_BREAK: begin
                    // Wait out a held-low line so it cannot be taken as a new start.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
